// File: rtl/alarm_controller.sv
// Alarm stage for the electronic clock: stores a BCD alarm time and rings when the live
// time reaches it. A ring ends on stop, on auto-timeout, or after a bounded number of snoozes.
module alarm_controller #(
  parameter int unsigned RING_TICKS   = 60,
  parameter int unsigned SNOOZE_TICKS = 300,
  parameter int unsigned MAX_SNOOZE   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       alarm_set_mode,
  input  logic       pb_left_pu,
  input  logic       pb_right_pu,
  input  logic       alarm_en,
  input  logic       stop_pu,
  input  logic       snooze_pu,
  input  logic [3:0] hr1_clock,
  input  logic [3:0] hr0_clock,
  input  logic [3:0] min1_clock,
  input  logic [3:0] min0_clock,
  output logic [3:0] alarm_hr1,
  output logic [3:0] alarm_hr0,
  output logic [3:0] alarm_min1,
  output logic [3:0] alarm_min0,
  output logic       set_field,
  output logic [1:0] state,
  output logic       ringing,
  output logic       led
);

  localparam int unsigned RW = $clog2(RING_TICKS) + 1;
  localparam int unsigned SW = $clog2(SNOOZE_TICKS) + 1;
  localparam int unsigned NW = $clog2(MAX_SNOOZE) + 1;
  localparam logic [RW-1:0] RingLast   = RW'(RING_TICKS - 1);
  localparam logic [SW-1:0] SnoozeLast = SW'(SNOOZE_TICKS - 1);
  localparam logic [NW-1:0] SnoozeMax  = NW'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRinging = 2'd1,
    StSnooze  = 2'd2
  } state_e;

  state_e        r_state, w_state_next;
  logic [3:0]    r_alarm_hr1, r_alarm_hr0, r_alarm_min1, r_alarm_min0;
  logic [3:0]    w_hr1_next, w_hr0_next, w_min1_next, w_min0_next;
  logic          r_set_field, w_set_field_next;
  logic [RW-1:0] r_ring_cnt, w_ring_cnt_next;
  logic [SW-1:0] r_snooze_cnt, w_snooze_cnt_next;
  logic [NW-1:0] r_snooze_num, w_snooze_num_next;
  logic          r_blink, w_blink_next;
  logic          r_match_d;
  logic          r_ringing, r_led;
  logic          w_match, w_trigger;

  assign w_match = (hr1_clock == r_alarm_hr1) && (hr0_clock == r_alarm_hr0) &&
                   (min1_clock == r_alarm_min1) && (min0_clock == r_alarm_min0);
  assign w_trigger = w_match & ~r_match_d & alarm_en & ~alarm_set_mode & (r_state == StIdle);

  // Increment uses the field selected before any same-cycle toggle.
  always_comb begin
    w_hr1_next       = r_alarm_hr1;
    w_hr0_next       = r_alarm_hr0;
    w_min1_next      = r_alarm_min1;
    w_min0_next      = r_alarm_min0;
    w_set_field_next = r_set_field;
    if (alarm_set_mode) begin
      if (pb_right_pu) begin
        if (!r_set_field) begin
          if (r_alarm_hr1 == 4'd2 && r_alarm_hr0 == 4'd3) begin
            w_hr1_next = 4'd0;
            w_hr0_next = 4'd0;
          end else if (r_alarm_hr0 == 4'd9) begin
            w_hr0_next = 4'd0;
            w_hr1_next = r_alarm_hr1 + 4'd1;
          end else begin
            w_hr0_next = r_alarm_hr0 + 4'd1;
          end
        end else begin
          if (r_alarm_min0 == 4'd9) begin
            w_min0_next = 4'd0;
            w_min1_next = (r_alarm_min1 == 4'd5) ? 4'd0 : r_alarm_min1 + 4'd1;
          end else begin
            w_min0_next = r_alarm_min0 + 4'd1;
          end
        end
      end
      if (pb_left_pu) w_set_field_next = ~r_set_field;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_ring_cnt_next   = r_ring_cnt;
    w_snooze_cnt_next = r_snooze_cnt;
    w_snooze_num_next = r_snooze_num;
    w_blink_next      = r_blink;
    unique case (r_state)
      StIdle: begin
        w_ring_cnt_next   = '0;
        w_snooze_cnt_next = '0;
        w_snooze_num_next = '0;
        w_blink_next      = 1'b0;
        if (w_trigger) w_state_next = StRinging;
      end
      StRinging: begin
        if (stop_pu) begin
          w_state_next = StIdle;
        end else if (snooze_pu) begin
          if (r_snooze_num < SnoozeMax) begin
            w_state_next      = StSnooze;
            w_snooze_num_next = r_snooze_num + NW'(1);
            w_snooze_cnt_next = '0;
          end else begin
            w_state_next = StIdle;
          end
        end else if (tick) begin
          if (r_ring_cnt == RingLast) begin
            w_state_next = StIdle;
          end else begin
            w_ring_cnt_next = r_ring_cnt + RW'(1);
            w_blink_next    = ~r_blink;
          end
        end
      end
      StSnooze: begin
        if (stop_pu) begin
          w_state_next = StIdle;
        end else if (tick) begin
          if (r_snooze_cnt == SnoozeLast) begin
            w_state_next    = StRinging;
            w_ring_cnt_next = '0;
            w_blink_next    = 1'b0;
          end else begin
            w_snooze_cnt_next = r_snooze_cnt + SW'(1);
          end
        end
      end
      default: w_state_next = StIdle;
    endcase
    // Disarm or editing overrides everything else.
    if (!alarm_en || alarm_set_mode) w_state_next = StIdle;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= StIdle;
      r_alarm_hr1  <= 4'd0;
      r_alarm_hr0  <= 4'd7;
      r_alarm_min1 <= 4'd0;
      r_alarm_min0 <= 4'd0;
      r_set_field  <= 1'b0;
      r_ring_cnt   <= '0;
      r_snooze_cnt <= '0;
      r_snooze_num <= '0;
      r_blink      <= 1'b0;
      r_match_d    <= 1'b1;
      r_ringing    <= 1'b0;
      r_led        <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_alarm_hr1  <= w_hr1_next;
      r_alarm_hr0  <= w_hr0_next;
      r_alarm_min1 <= w_min1_next;
      r_alarm_min0 <= w_min0_next;
      r_set_field  <= w_set_field_next;
      r_ring_cnt   <= w_ring_cnt_next;
      r_snooze_cnt <= w_snooze_cnt_next;
      r_snooze_num <= w_snooze_num_next;
      r_blink      <= w_blink_next;
      r_match_d    <= w_match;
      r_ringing    <= (w_state_next == StRinging);
      r_led        <= (w_state_next == StRinging) & w_blink_next;
    end
  end

  assign alarm_hr1  = r_alarm_hr1;
  assign alarm_hr0  = r_alarm_hr0;
  assign alarm_min1 = r_alarm_min1;
  assign alarm_min0 = r_alarm_min0;
  assign set_field  = r_set_field;
  assign state      = r_state;
  assign ringing    = r_ringing;
  assign led        = r_led;

endmodule

// File: tb/tb_alarm_controller.sv
// Self-checking bench for alarm_controller: expected values are queued as stimulus is
// driven and popped for comparison once the DUT output has settled.
module tb_alarm_controller;

  logic       clk = 1'b0;
  logic       reset, tick, alarm_set_mode, pb_left_pu, pb_right_pu;
  logic       alarm_en, stop_pu, snooze_pu;
  logic [3:0] hr1_clock, hr0_clock, min1_clock, min0_clock;
  logic [3:0] alarm_hr1, alarm_hr0, alarm_min1, alarm_min0;
  logic       set_field, ringing, led;
  logic [1:0] state;

  logic [15:0] exp_q[$];
  logic [15:0] exp_v, got_v;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  alarm_controller dut (
    .clk            (clk),
    .reset          (reset),
    .tick           (tick),
    .alarm_set_mode (alarm_set_mode),
    .pb_left_pu     (pb_left_pu),
    .pb_right_pu    (pb_right_pu),
    .alarm_en       (alarm_en),
    .stop_pu        (stop_pu),
    .snooze_pu      (snooze_pu),
    .hr1_clock      (hr1_clock),
    .hr0_clock      (hr0_clock),
    .min1_clock     (min1_clock),
    .min0_clock     (min0_clock),
    .alarm_hr1      (alarm_hr1),
    .alarm_hr0      (alarm_hr0),
    .alarm_min1     (alarm_min1),
    .alarm_min0     (alarm_min0),
    .set_field      (set_field),
    .state          (state),
    .ringing        (ringing),
    .led            (led)
  );

  function automatic logic [15:0] st_vec(int s, int r, int l);
    return {12'd0, 2'(s), 1'(r), 1'(l)};
  endfunction

  function automatic logic [15:0] cur_st();
    return {12'd0, state, ringing, led};
  endfunction

  function automatic logic [15:0] cur_alarm();
    return {alarm_hr1, alarm_hr0, alarm_min1, alarm_min0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_live(int h, int m);
    hr1_clock  = 4'(h / 10);
    hr0_clock  = 4'(h % 10);
    min1_clock = 4'(m / 10);
    min0_clock = 4'(m % 10);
  endtask

  task automatic do_reset();
    tick = 0; alarm_set_mode = 0; pb_left_pu = 0; pb_right_pu = 0;
    stop_pu = 0; snooze_pu = 0; alarm_en = 1;
    set_live(6, 59);
    reset = 1;
    step();
    step();
    reset = 0;
    step();
  endtask

  task automatic ring_up();
    set_live(6, 59);
    step();
    set_live(7, 0);
    step();
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1;
    #1;
    exp_q.push_back(16'h0700);
    exp_q.push_back(st_vec(0, 0, 0));
    exp_q.push_back(16'h0000);
    got_v = cur_alarm(); exp_v = exp_q.pop_front(); n_checks++;
    if (got_v !== exp_v) begin
      n_fail++; $display("FAIL reset_alarm: got %h expected %h", got_v, exp_v);
    end
    got_v = cur_st(); exp_v = exp_q.pop_front(); n_checks++;
    if (got_v !== exp_v) begin
      n_fail++; $display("FAIL reset_state: got %h expected %h", got_v, exp_v);
    end
    got_v = {15'd0, set_field}; exp_v = exp_q.pop_front(); n_checks++;
    if (got_v !== exp_v) begin
      n_fail++; $display("FAIL reset_field: got %h expected %h", got_v, exp_v);
    end
    step();
    reset = 0;
    step();
  endtask

  task automatic test_set_alarm();
    int h = 7;
    int m = 0;
    do_reset();
    alarm_set_mode = 1;
    step();
    for (int i = 0; i < 24; i++) begin
      h = (h + 1) % 24;
      exp_q.push_back({4'(h / 10), 4'(h % 10), 8'h00});
      pb_right_pu = 1; step(); pb_right_pu = 0;
      got_v = cur_alarm(); exp_v = exp_q.pop_front(); n_checks++;
      if (got_v !== exp_v) begin
        n_fail++; $display("FAIL set_hour%0d: got %h expected %h", i, got_v, exp_v);
      end
    end
    exp_q.push_back(16'h0001);
    pb_left_pu = 1; step(); pb_left_pu = 0;
    got_v = {15'd0, set_field}; exp_v = exp_q.pop_front(); n_checks++;
    if (got_v !== exp_v) begin
      n_fail++; $display("FAIL field_toggle: got %h expected %h", got_v, exp_v);
    end
    for (int i = 0; i < 61; i++) begin
      m = (m + 1) % 60;
      exp_q.push_back({8'h07, 4'(m / 10), 4'(m % 10)});
      pb_right_pu = 1; step(); pb_right_pu = 0;
      got_v = cur_alarm(); exp_v = exp_q.pop_front(); n_checks++;
      if (got_v !== exp_v) begin
        n_fail++; $display("FAIL set_min%0d: got %h expected %h", i, got_v, exp_v);
      end
    end
    // Both buttons: minutes 01 -> 02, then the field flips back to hours.
    exp_q.push_back({16'h0702});
    exp_q.push_back(16'h0000);
    pb_left_pu = 1; pb_right_pu = 1; step(); pb_left_pu = 0; pb_right_pu = 0;
    got_v = cur_alarm(); exp_v = exp_q.pop_front(); n_checks++;
    if (got_v !== exp_v) begin
      n_fail++; $display("FAIL both_btn_alarm: got %h expected %h", got_v, exp_v);
    end
    got_v = {15'd0, set_field}; exp_v = exp_q.pop_front(); n_checks++;
    if (got_v !== exp_v) begin
      n_fail++; $display("FAIL both_btn_field: got %h expected %h", got_v, exp_v);
    end
    alarm_set_mode = 0;
    exp_q.push_back(16'h0702);
    pb_right_pu = 1; pb_left_pu = 1; step(); pb_right_pu = 0; pb_left_pu = 0;
    got_v = cur_alarm(); exp_v = exp_q.pop_front(); n_checks++;
    if (got_v !== exp_v) begin
      n_fail++; $display("FAIL ignore_btn: got %h expected %h", got_v, exp_v);
    end
  endtask

  task automatic test_ring_timeout();
    do_reset();
    step();
    exp_q.push_back(st_vec(0, 0, 0));
    got_v = cur_st(); exp_v = exp_q.pop_front(); n_checks++;
    if (got_v !== exp_v) begin
      n_fail++; $display("FAIL pre_match: got %h expected %h", got_v, exp_v);
    end
    exp_q.push_back(st_vec(1, 1, 0));
    ring_up();
    got_v = cur_st(); exp_v = exp_q.pop_front(); n_checks++;
    if (got_v !== exp_v) begin
      n_fail++; $display("FAIL ring_start: got %h expected %h", got_v, exp_v);
    end
    for (int k = 1; k <= 60; k++) begin
      exp_q.push_back((k < 60) ? st_vec(1, 1, k % 2) : st_vec(0, 0, 0));
      tick = 1; step(); tick = 0;
      got_v = cur_st(); exp_v = exp_q.pop_front(); n_checks++;
      if (got_v !== exp_v) begin
        n_fail++; $display("FAIL ring_tick%0d: got %h expected %h", k, got_v, exp_v);
      end
    end
    exp_q.push_back(st_vec(0, 0, 0));
    repeat (5) step();
    got_v = cur_st(); exp_v = exp_q.pop_front(); n_checks++;
    if (got_v !== exp_v) begin
      n_fail++; $display("FAIL no_retrigger: got %h expected %h", got_v, exp_v);
    end
  endtask

  task automatic test_snooze();
    do_reset();
    ring_up();
    for (int s = 1; s <= 3; s++) begin
      exp_q.push_back(st_vec(2, 0, 0));
      snooze_pu = 1; step(); snooze_pu = 0;
      got_v = cur_st(); exp_v = exp_q.pop_front(); n_checks++;
      if (got_v !== exp_v) begin
        n_fail++; $display("FAIL snooze_enter%0d: got %h expected %h", s, got_v, exp_v);
      end
      if (s == 1) begin
        exp_q.push_back(st_vec(2, 0, 0));
        snooze_pu = 1; step(); snooze_pu = 0;
        got_v = cur_st(); exp_v = exp_q.pop_front(); n_checks++;
        if (got_v !== exp_v) begin
          n_fail++; $display("FAIL snooze_ignored: got %h expected %h", got_v, exp_v);
        end
      end
      for (int k = 1; k <= 300; k++) begin
        if (k == 299) exp_q.push_back(st_vec(2, 0, 0));
        if (k == 300) exp_q.push_back(st_vec(1, 1, 0));
        tick = 1; step(); tick = 0;
        if (k >= 299) begin
          got_v = cur_st(); exp_v = exp_q.pop_front(); n_checks++;
          if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL snooze%0d_tick%0d: got %h expected %h", s, k, got_v, exp_v);
          end
        end
      end
    end
    exp_q.push_back(st_vec(0, 0, 0));
    snooze_pu = 1; step(); snooze_pu = 0;
    got_v = cur_st(); exp_v = exp_q.pop_front(); n_checks++;
    if (got_v !== exp_v) begin
      n_fail++; $display("FAIL snooze_limit: got %h expected %h", got_v, exp_v);
    end
  endtask

  task automatic test_stop_and_disarm();
    do_reset();
    ring_up();
    exp_q.push_back(st_vec(0, 0, 0));
    stop_pu = 1; snooze_pu = 1; step(); stop_pu = 0; snooze_pu = 0;
    got_v = cur_st(); exp_v = exp_q.pop_front(); n_checks++;
    if (got_v !== exp_v) begin
      n_fail++; $display("FAIL stop_wins: got %h expected %h", got_v, exp_v);
    end
    ring_up();
    exp_q.push_back(st_vec(1, 1, 0));
    exp_q.push_back(st_vec(2, 0, 0));
    exp_q.push_back(st_vec(0, 0, 0));
    got_v = cur_st(); exp_v = exp_q.pop_front(); n_checks++;
    if (got_v !== exp_v) begin
      n_fail++; $display("FAIL rering: got %h expected %h", got_v, exp_v);
    end
    snooze_pu = 1; step(); snooze_pu = 0;
    got_v = cur_st(); exp_v = exp_q.pop_front(); n_checks++;
    if (got_v !== exp_v) begin
      n_fail++; $display("FAIL snooze_again: got %h expected %h", got_v, exp_v);
    end
    alarm_en = 0; step();
    got_v = cur_st(); exp_v = exp_q.pop_front(); n_checks++;
    if (got_v !== exp_v) begin
      n_fail++; $display("FAIL disarm_snooze: got %h expected %h", got_v, exp_v);
    end
    alarm_en = 1;
  endtask

  task automatic test_reset_mid_ring();
    do_reset();
    alarm_set_mode = 1;
    pb_left_pu = 1; step(); pb_left_pu = 0;
    pb_right_pu = 1; step(); pb_right_pu = 0;
    alarm_set_mode = 0;
    set_live(7, 0); step();
    set_live(7, 1); step();
    exp_q.push_back(st_vec(1, 1, 1));
    tick = 1; step(); tick = 0;
    got_v = cur_st(); exp_v = exp_q.pop_front(); n_checks++;
    if (got_v !== exp_v) begin
      n_fail++; $display("FAIL ring_0701: got %h expected %h", got_v, exp_v);
    end
    exp_q.push_back(st_vec(0, 0, 0));
    exp_q.push_back({16'h0700});
    exp_q.push_back(16'h0000);
    #2;
    reset = 1;
    #1;
    got_v = cur_st(); exp_v = exp_q.pop_front(); n_checks++;
    if (got_v !== exp_v) begin
      n_fail++; $display("FAIL async_rst_state: got %h expected %h", got_v, exp_v);
    end
    got_v = cur_alarm(); exp_v = exp_q.pop_front(); n_checks++;
    if (got_v !== exp_v) begin
      n_fail++; $display("FAIL async_rst_alarm: got %h expected %h", got_v, exp_v);
    end
    got_v = {15'd0, set_field}; exp_v = exp_q.pop_front(); n_checks++;
    if (got_v !== exp_v) begin
      n_fail++; $display("FAIL async_rst_field: got %h expected %h", got_v, exp_v);
    end
    step();
    reset = 0;
    step();
  endtask

  task automatic test_set_mode_no_ring();
    do_reset();
    alarm_set_mode = 1;
    ring_up();
    step();
    exp_q.push_back(st_vec(0, 0, 0));
    exp_q.push_back(st_vec(0, 0, 0));
    got_v = cur_st(); exp_v = exp_q.pop_front(); n_checks++;
    if (got_v !== exp_v) begin
      n_fail++; $display("FAIL setmode_no_ring: got %h expected %h", got_v, exp_v);
    end
    alarm_set_mode = 0;
    repeat (2) step();
    got_v = cur_st(); exp_v = exp_q.pop_front(); n_checks++;
    if (got_v !== exp_v) begin
      n_fail++; $display("FAIL setmode_exit: got %h expected %h", got_v, exp_v);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_set_alarm();
    test_ring_timeout();
    test_snooze();
    test_stop_and_disarm();
    test_reset_mid_ring();
    test_set_mode_no_ring();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
